imem_fetch_ctrl: RTL and testbench

Fetch sequencer for `instruction_memory`. It owns the program counter and drives the memory's byte address. It tracks the memory's one-cycle registered read latency and delivers {pc, instr} to decode over a valid/ready handshake. It absorbs decode back-pressure with a one-entry skid buffer, applies branch/jump redirects with squash, and stops on a halt word or an out-of-range fetch.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_skid_buf.sv | 61 ++++++
 rtl/imem_fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
//   fetch_state_e : controller state encoding
//   HALT_WORD     : instruction word that stops fetching
//   INSTR_BYTES   : bytes per instruction word (pc increment)
package fetch_pkg;

  localparam int unsigned PC_W        = 64;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  // {pc, instr} pair handed to decode
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding register that absorbs a single response
// while decode is stalled.
//   clk, reset_n : clock, async active-low reset
//   push_i       : capture pc_i/instr_i (only legal while empty)
//   pop_i        : entry consumed by decode
//   flush_i      : discard the entry (redirect); wins over push/pop
//   pc_o/instr_o : held entry
//   full_o       : entry valid
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               full_o
);

  logic               full_q,  full_d;
  logic [PC_W-1:0]    pc_q,    pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // Entry register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next entry state
  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (push_i) begin
      full_d  = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign full_o  = full_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for instruction_memory: owns the pc, tracks the memory's
// one-cycle read latency, and offers {instr_pc, instr} to decode over
// valid/ready with a one-entry skid, redirect squash, halt and bounds fault.
//   clk, reset_n         : clock, async active-low reset
//   start                : leave IDLE, begin fetching at RESET_PC
//   mem_addr / mem_instr : memory address out, read data in (next cycle)
//   instr_valid/ready    : decode handshake; instr, instr_pc are the payload
//   redirect_valid/pc    : single-cycle branch/jump redirect
//   halted, fault        : level status of the sticky stop states
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 4095,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [63:0] mem_addr,
  input  logic [31:0] mem_instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        halted,
  output logic        fault
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               pend_q, pend_d;
  logic [PC_W-1:0]    pend_pc_q, pend_pc_d;

  logic               skid_push, skid_pop, skid_flush, skid_full;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  logic               resp_valid, resp_is_halt;
  logic [PC_W:0]      pc_last_byte;
  logic [PC_W:0]      mem_last_byte;
  fetch_entry_t       out_entry;
  logic               out_valid;

  assign resp_valid   = pend_q;
  assign resp_is_halt = resp_valid && (mem_instr == HALT_WORD);

  // 65-bit so a pc near the top of the address space cannot wrap into range
  assign pc_last_byte  = {1'b0, pc_q} + (PC_W+1)'(INSTR_BYTES - 1);
  assign mem_last_byte = (PC_W+1)'(MEM_SIZE) - (PC_W+1)'(1);

  fetch_skid_buf u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .flush_i (skid_flush),
    .pc_i    (pend_pc_q),
    .instr_i (mem_instr),
    .pc_o    (skid_pc),
    .instr_o (skid_instr),
    .full_o  (skid_full)
  );

  // Controller state, pc and in-flight request tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next state, issue decision and decode-facing output mux
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = 1'b0;
    pend_pc_d  = pend_pc_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_flush = 1'b0;
    out_valid  = 1'b0;
    out_entry  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end

      RUN: begin
        if (redirect_valid) begin
          skid_flush = 1'b1;
          if (redirect_pc[1:0] != 2'b00) state_d = FAULT;
          else                           pc_d    = redirect_pc;
        end else if (!skid_full && resp_is_halt) begin
          // pend is never set while the skid is full, so this is the live response
          state_d = HALT;
          pc_d    = pend_pc_q;
        end else begin
          if (skid_full) begin
            out_valid = 1'b1;
            out_entry = '{pc: skid_pc, instr: skid_instr};
          end else if (resp_valid) begin
            out_valid = 1'b1;
            out_entry = '{pc: pend_pc_q, instr: mem_instr};
          end
          skid_pop  = skid_full && instr_ready;
          skid_push = !skid_full && resp_valid && !instr_ready;

          // Issue opportunity: nothing waiting anywhere that decode has refused
          if (!skid_full && !(resp_valid && !instr_ready)) begin
            if (pc_last_byte > mem_last_byte) begin
              state_d = FAULT;
            end else begin
              pend_d    = 1'b1;
              pend_pc_d = pc_q;
              pc_d      = pc_q + PC_W'(INSTR_BYTES);
            end
          end
        end
      end

      default: ;
    endcase
  end

  assign mem_addr    = pc_q;
  assign instr_valid = out_valid;
  assign instr       = out_entry.instr;
  assign instr_pc    = out_entry.pc;
  assign halted      = (state_q == HALT);
  assign fault       = (state_q == FAULT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed, scoreboard-checked bench for imem_fetch_ctrl with a behavioural
// registered-read instruction memory.
module tb_imem_fetch_ctrl;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [63:0] mem_addr, mem_addr_b;
  logic [31:0] mem_instr, mem_instr_b;
  logic        instr_valid, instr_valid_b;
  logic        instr_ready;
  logic [31:0] instr, instr_b;
  logic [63:0] instr_pc, instr_pc_b;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted, halted_b;
  logic        fault, fault_b;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.MEM_SIZE(4095), .RESET_PC(64'h0)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .mem_addr(mem_addr), .mem_instr(mem_instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .fault(fault)
  );

  // Second instance whose reset pc does not fit a whole word in memory
  imem_fetch_ctrl #(.MEM_SIZE(4095), .RESET_PC(64'd4092)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start),
    .mem_addr(mem_addr_b), .mem_instr(mem_instr_b),
    .instr_valid(instr_valid_b), .instr_ready(instr_ready),
    .instr(instr_b), .instr_pc(instr_pc_b),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted_b), .fault(fault_b)
  );

  function automatic logic [31:0] wd(input int i);
    return 32'hA500_0000 | 32'(i + 1);
  endfunction

  function automatic logic [31:0] rd(input logic [63:0] a);
    if (a < 64'd256) return mem[a[7:2]];
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) mem_instr <= 32'h0;
    else          mem_instr <= rd(mem_addr);
  end

  always @(posedge clk) begin
    if (!reset_n) mem_instr_b <= 32'h0;
    else          mem_instr_b <= 32'h0000_0013;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs for this cycle and score any handshake
  task automatic drive(input logic st, input logic rdy, input logic rv, input logic [63:0] rpc);
    exp_t e;
    start = st; instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    chk("b_never_valid", 64'(instr_valid_b), 64'd0);
    if (instr_valid && instr_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underrun observed_pc=%0h expected=none", instr_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("hs_pc", instr_pc, e.pc);
        chk("hs_instr", 64'(instr), 64'(e.instr));
      end
    end
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic load(input int zero_at);
    for (int i = 0; i < 64; i++) mem[i] = wd(i);
    mem[zero_at] = 32'h0;
  endtask

  task automatic push_exp(input int first, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++)
      sb.push_back('{pc: base + 64'(4 * i), instr: wd(first + i)});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    adv(); adv();
    reset_n = 1'b1;
  endtask

  task automatic run_to_halt(input string tag);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      drive(1'b0, 1'b1, 1'b0, 64'h0);
      if (halted) seen = 1;
      adv();
    end
    chk(tag, 64'(halted), 64'd1);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset values ----
    load(4);
    reset_n = 1'b0;
    start = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    adv(); adv();
    #1;
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_b_mem_addr", mem_addr_b, 64'd4092);
    adv();
    reset_n = 1'b1;

    // ---- straight-line stream into halt word ----
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    chk("idle_valid", 64'(instr_valid), 64'd0);
    chk("idle_mem_addr", mem_addr, 64'h0);
    adv();
    push_exp(0, 4, 64'h0);
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    chk("start_valid", 64'(instr_valid), 64'd0);
    adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    chk("issue_cycle_valid", 64'(instr_valid), 64'd0);
    chk("b_fault_not_yet", 64'(fault_b), 64'd0);
    adv();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 64'h0);
      chk("stream_valid", 64'(instr_valid), 64'd1);
      chk("stream_pc", instr_pc, 64'(4 * i));
      if (i == 0) chk("b_fault_first_issue", 64'(fault_b), 64'd1);
      adv();
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    chk("halt_word_not_offered", 64'(instr_valid), 64'd0);
    chk("halted_not_yet", 64'(halted), 64'd0);
    adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    chk("halted_rise", 64'(halted), 64'd1);
    chk("halt_pc_frozen", mem_addr, 64'd16);
    chk("halt_no_valid", 64'(instr_valid), 64'd0);
    adv();
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    chk("halt_sticky_valid", 64'(instr_valid), 64'd0);
    adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    chk("halt_sticky", 64'(halted), 64'd1);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);
    chk("b_fault_sticky", 64'(fault_b), 64'd1);
    chk("b_instr", 64'(instr_b), 64'd0);
    chk("b_instr_pc", instr_pc_b, 64'd0);
    chk("b_halted", 64'(halted_b), 64'd0);
    adv();

    // ---- decode stall absorbed by the skid ----
    load(10);
    do_reset();
    push_exp(0, 10, 64'h0);
    drive(1'b1, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0); adv();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      chk("stall_valid", 64'(instr_valid), 64'd1);
      chk("stall_pc", instr_pc, 64'd8);
      chk("stall_instr", 64'(instr), 64'(wd(2)));
      adv();
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    chk("release_pc", instr_pc, 64'd8);
    adv();
    run_to_halt("t2_halt");
    chk("t2_halt_pc", mem_addr, 64'd40);

    // ---- redirect squashes pc 8 ----
    load(10);
    do_reset();
    sb.push_back('{pc: 64'h0,  instr: wd(0)});
    sb.push_back('{pc: 64'h4,  instr: wd(1)});
    sb.push_back('{pc: 64'h20, instr: wd(8)});
    sb.push_back('{pc: 64'h24, instr: wd(9)});
    drive(1'b1, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b1, 64'h20);
    chk("redir_squash_valid", 64'(instr_valid), 64'd0);
    adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    chk("redir_issue_valid", 64'(instr_valid), 64'd0);
    adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    chk("redir_target_valid", 64'(instr_valid), 64'd1);
    chk("redir_target_pc", instr_pc, 64'h20);
    adv();
    run_to_halt("t3_halt");

    // ---- misaligned redirect faults ----
    load(40);
    do_reset();
    sb.push_back('{pc: 64'h0, instr: wd(0)});
    drive(1'b1, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b1, 64'h22);
    chk("misalign_valid", 64'(instr_valid), 64'd0);
    chk("misalign_fault_not_yet", 64'(fault), 64'd0);
    adv();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 64'h0);
      chk("misalign_fault", 64'(fault), 64'd1);
      chk("misalign_no_valid", 64'(instr_valid), 64'd0);
      chk("misalign_not_halted", 64'(halted), 64'd0);
      adv();
    end
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // ---- async reset with the skid full, then restart ----
    load(10);
    do_reset();
    push_exp(0, 2, 64'h0);
    drive(1'b1, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b0, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    chk("skid_full_valid", 64'(instr_valid), 64'd1);
    chk("skid_full_pc", instr_pc, 64'd8);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(instr_valid), 64'd0);
    chk("arst_instr", 64'(instr), 64'd0);
    chk("arst_instr_pc", instr_pc, 64'd0);
    chk("arst_mem_addr", mem_addr, 64'h0);
    chk("arst_halted", 64'(halted), 64'd0);
    chk("arst_fault", 64'(fault), 64'd0);
    adv(); adv();
    reset_n = 1'b1;
    sb.delete();
    push_exp(0, 10, 64'h0);
    drive(1'b1, 1'b1, 1'b0, 64'h0); adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    chk("restart_issue_valid", 64'(instr_valid), 64'd0);
    adv();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    chk("restart_valid", 64'(instr_valid), 64'd1);
    chk("restart_pc", instr_pc, 64'h0);
    adv();
    run_to_halt("t6_halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
